// File: rtl/cfg_loader.sv
// Byte-stream configuration loader: turns addressed, broadcast or sequential
// stream writes into a shared cfg_out bus plus one-hot per-block write strobes.
module cfg_loader #(
  parameter int NUM_BLOCKS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  stream_mode,
  output logic [7:0]            cfg_out,
  output logic [NUM_BLOCKS-1:0] set_x,
  output logic [NUM_BLOCKS-1:0] set_y,
  output logic [NUM_BLOCKS-1:0] set_ab,
  output logic [NUM_BLOCKS-1:0] set_cx,
  output logic                  done,
  output logic                  cmd_err
);

  localparam int              W_W    = $clog2(4 * NUM_BLOCKS);
  localparam logic [W_W-1:0] W_LAST = W_W'(4 * NUM_BLOCKS - 1);

  typedef enum logic [1:0] {S_ADDR, S_DATA, S_STROBE, S_STREAM} state_t;

  state_t                  state, state_nxt;
  logic [W_W-1:0]          w;
  logic [7:0]              addr;
  logic                    accept;
  logic                    load;
  logic [1:0]              sel_reg;
  logic [NUM_BLOCKS-1:0]   sel_vec;
  logic                    sel_err;
  logic                    sel_last;

  function automatic logic [NUM_BLOCKS-1:0] block_vec(input int idx);
    logic [NUM_BLOCKS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (i == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign cfg_ready = (state != S_STROBE);
  assign accept    = cfg_valid && cfg_ready;
  assign load      = accept && ((state == S_DATA) || (state == S_STREAM && stream_mode));

  always_comb begin
    state_nxt = state;
    case (state)
      S_ADDR: begin
        if (stream_mode)  state_nxt = S_STREAM;
        else if (accept)  state_nxt = S_DATA;
      end
      S_DATA: begin
        if (accept) state_nxt = S_STROBE;
      end
      S_STROBE: begin
        state_nxt = stream_mode ? S_STREAM : S_ADDR;
      end
      S_STREAM: begin
        if (!stream_mode) state_nxt = S_ADDR;
        else if (accept)  state_nxt = S_STROBE;
      end
      default: state_nxt = S_ADDR;
    endcase
  end

  // Target decode: stream position in S_STREAM, latched address otherwise
  always_comb begin
    sel_reg  = addr[7:6];
    sel_vec  = '0;
    sel_err  = 1'b0;
    sel_last = 1'b0;
    if (state == S_STREAM) begin
      sel_reg  = w[1:0];
      sel_vec  = block_vec(int'(w >> 2));
      sel_last = (w == W_LAST);
    end else if (addr[5:0] == 6'd63) begin
      sel_vec = '1;
    end else if (int'(addr[5:0]) < NUM_BLOCKS) begin
      sel_vec = block_vec(int'(addr[5:0]));
    end else begin
      sel_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_ADDR;
      w       <= '0;
      addr    <= '0;
      cfg_out <= '0;
      set_x   <= '0;
      set_y   <= '0;
      set_ab  <= '0;
      set_cx  <= '0;
      done    <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      set_x   <= '0;
      set_y   <= '0;
      set_ab  <= '0;
      set_cx  <= '0;
      done    <= 1'b0;
      cmd_err <= 1'b0;
      if (state == S_ADDR && !stream_mode && accept) addr <= cfg_data;
      if (load) begin
        cfg_out <= cfg_data;
        cmd_err <= sel_err;
        done    <= sel_last;
        case (sel_reg)
          2'd0:    set_x  <= sel_vec;
          2'd1:    set_y  <= sel_vec;
          2'd2:    set_ab <= sel_vec;
          default: set_cx <= sel_vec;
        endcase
        if (state == S_STREAM) w <= sel_last ? '0 : w + 1'b1;
      end
      // Leaving stream mode abandons any partial load
      if ((state == S_STREAM || state == S_STROBE) && !stream_mode) w <= '0;
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed bench for cfg_loader: addressed/broadcast/error table, stream load,
// abort, mode change between bytes and asynchronous reset mid-stream.
module tb_cfg_loader;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   cfg_data = '0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic         stream_mode = 1'b0;
  logic [7:0]   cfg_out;
  logic [N-1:0] set_x, set_y, set_ab, set_cx;
  logic         done, cmd_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  cfg_loader #(.NUM_BLOCKS(N)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .stream_mode(stream_mode), .cfg_out(cfg_out),
    .set_x(set_x), .set_y(set_y), .set_ab(set_ab), .set_cx(set_cx),
    .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic [7:0]   addr;
    logic [7:0]   data;
    int           reg_sel;
    logic [N-1:0] vec;
    logic         err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] strb(input int r, input logic [N-1:0] v);
    case (r)
      0:       return {v, 48'h0};
      1:       return {16'h0, v, 32'h0};
      2:       return {32'h0, v, 16'h0};
      default: return {48'h0, v};
    endcase
  endfunction

  function automatic logic [63:0] strobes();
    return {set_x, set_y, set_ab, set_cx};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    cfg_valid = 1'b1;
    cfg_data  = b;
    n = 0;
    while (!cfg_ready && n < 20) begin
      step();
      n++;
    end
    if (!cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got cfg_ready=0 expected 1 within 20 cycles");
    end
    step();
    cfg_valid = 1'b0;
  endtask

  // Stream byte then check the strobe cycle that follows
  task automatic stream_byte(input logic [7:0] b, input int k, input logic exp_done);
    send_byte(b);
    chk("stream_cfg_out", cfg_out, b);
    chk("stream_strobe", strobes(), strb(k % 4, N'(1) << (k / 4)));
    chk("stream_done", done, exp_done);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'h85, 8'h3C, 2, N'(1) << 5, 1'b0};
    tbl[1] = '{8'h3F, 8'hAA, 0, '1,          1'b0};
    tbl[2] = '{8'h50, 8'h11, 1, '0,          1'b1};
    tbl[3] = '{8'h00, 8'h01, 0, N'(1),       1'b0};
    tbl[4] = '{8'h4F, 8'h77, 1, N'(1) << 15, 1'b0};
    tbl[5] = '{8'hC7, 8'hE5, 3, N'(1) << 7,  1'b0};
    tbl[6] = '{8'hFF, 8'h5A, 3, '1,          1'b0};
    tbl[7] = '{8'hBE, 8'h99, 2, '0,          1'b1};

    // Reset held with valid toggling
    for (int i = 0; i < 4; i++) begin
      cfg_valid = ~cfg_valid;
      cfg_data  = 8'h85;
      step();
    end
    chk("rst_strobes", strobes(), 64'h0);
    chk("rst_cfg_out", cfg_out, 8'h00);
    chk("rst_flags", {done, cmd_err}, 2'b00);
    cfg_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_idle_strobes", strobes(), 64'h0);

    // Addressed / broadcast / error table
    for (int i = 0; i < 8; i++) begin
      send_byte(tbl[i].addr);
      chk("addr_no_strobe", strobes(), 64'h0);
      send_byte(tbl[i].data);
      chk("tbl_cfg_out", cfg_out, tbl[i].data);
      chk("tbl_strobe", strobes(), strb(tbl[i].reg_sel, tbl[i].vec));
      chk("tbl_cmd_err", cmd_err, tbl[i].err);
      chk("tbl_ready_low", cfg_ready, 1'b0);
      chk("tbl_done", done, 1'b0);
      step();
      chk("tbl_strobe_one_cycle", {strobes(), cmd_err}, 65'h0);
      chk("tbl_hold_cfg_out", cfg_out, tbl[i].data);
      chk("tbl_ready_back", cfg_ready, 1'b1);
    end

    // Full stream load with random valid gaps
    stream_mode = 1'b1;
    step();
    for (int k = 0; k < 64; k++) begin
      repeat ($urandom_range(0, 2)) step();
      stream_byte(8'(k), k, k == 63);
    end
    stream_byte(8'h40, 0, 1'b0);
    step();
    chk("stream_done_count", done_cnt, 1);

    // Abort after 10 bytes
    stream_mode = 1'b0;
    step();
    step();
    stream_mode = 1'b1;
    step();
    for (int k = 0; k < 10; k++) stream_byte(8'(8'h80 + k), k, 1'b0);
    stream_mode = 1'b0;
    step();
    step();
    send_byte(8'h01);
    send_byte(8'h22);
    chk("abort_addr_write", strobes(), strb(0, N'(1) << 1));
    chk("abort_no_done", done_cnt, 1);
    stream_mode = 1'b1;
    step();
    step();
    stream_byte(8'h33, 0, 1'b0);

    // stream_mode raised between address and data bytes
    stream_mode = 1'b0;
    step();
    step();
    send_byte(8'h42);
    stream_mode = 1'b1;
    send_byte(8'h5D);
    chk("mode_mid_cmd_cfg_out", cfg_out, 8'h5D);
    chk("mode_mid_cmd_strobe", strobes(), strb(1, N'(1) << 2));
    stream_byte(8'h66, 0, 1'b0);

    // Asynchronous reset during a strobe cycle
    stream_byte(8'h01, 1, 1'b0);
    stream_byte(8'h02, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_strobe", strobes(), 64'h0);
    chk("async_rst_cfg_out", cfg_out, 8'h00);
    stream_mode = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", cfg_ready, 1'b1);
    send_byte(8'h43);
    send_byte(8'hC3);
    chk("post_rst_addr_write", strobes(), strb(1, N'(1) << 3));
    stream_mode = 1'b1;
    step();
    step();
    stream_byte(8'h44, 0, 1'b0);
    chk("post_rst_done_count", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cfg_loader.md
# cfg_loader

Configuration front end for the logic-block array. Accepts a byte stream over a valid/ready handshake and converts it into the shared configuration bus `cfg_out` plus one-hot per-block write strobes (`set_x`, `set_y`, `set_ab`, `set_cx`) that drive each logic block's `cfg_in` and `set_*` inputs. Supports addressed single writes, broadcast writes and a sequential full-array stream load.

## Interface

- `NUM_BLOCKS`, default 16: number of logic blocks driven; legal range 1..63.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_data`  in  8  incoming configuration byte.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_ready`  out  1  loader can accept a byte this cycle.
- `stream_mode`  in  1  level; 1 selects sequential stream load, 0 selects addressed mode.
- `cfg_out`  out  8  configuration byte broadcast to all blocks' `cfg_in`.
- `set_x`  out  NUM_BLOCKS  one-hot (or all-ones on broadcast) write strobe for the LUT-x register.
- `set_y`  out  NUM_BLOCKS  strobe for the LUT-y register.
- `set_ab`  out  NUM_BLOCKS  strobe for the a/b input-select register.
- `set_cx`  out  NUM_BLOCKS  strobe for the c-select/control register.
- `done`  out  1  one-cycle pulse when a stream load writes its last byte.
- `cmd_err`  out  1  one-cycle pulse when an addressed command is dropped.

## Operation

- Transfer: byte accepted on a rising edge where `cfg_valid && cfg_ready`.
- States: S_ADDR, S_DATA, S_STROBE, S_STREAM.
- Address byte (addressed mode): [7:6] register select (00 = x, 01 = y, 10 = ab, 11 = cx); [5:0] block index. Index 63 means broadcast to all NUM_BLOCKS.
- S_ADDR: on accept, latch the address byte and go to S_DATA. If `stream_mode` = 1 while in S_ADDR, go to S_STREAM with word counter = 0 and accept nothing that cycle.
- S_DATA: on accept, latch the byte into `cfg_out` and go to S_STROBE. `stream_mode` is ignored here; the pending command always completes.
- S_STROBE: exactly one `set_*` vector is active for this cycle only.
  - Bit set = latched index, or all bits on broadcast.
  - Index ≥ NUM_BLOCKS and ≠ 63: no strobe; `cmd_err` pulses instead.
  - Next state is S_STREAM if `stream_mode` = 1, else S_ADDR.
- S_STREAM: every accepted byte is data.
  - Word counter w (width ceil(log2(4·NUM_BLOCKS))) gives block = w>>2 and register = w[1:0], using the same encoding as above.
  - On accept: latch the byte into `cfg_out`, go to S_STROBE, and increment w.
  - On the byte with w = 4·NUM_BLOCKS−1: `done` pulses in the following S_STROBE cycle and w wraps to 0.
- `stream_mode` = 0 observed in S_STREAM: return to S_ADDR and clear w. A partial stream is abandoned with no `done`.
- Re-entering S_STREAM always restarts at w = 0.
- `cfg_ready` = 1 in S_ADDR, S_DATA and S_STREAM; 0 in S_STROBE.

## Timing

- Reset values (asynchronous, immediate):
  - State S_ADDR, w = 0, latched address = 0.
  - `cfg_out` = 0; all `set_*` = 0; `done` = 0; `cmd_err` = 0.
  - `cfg_ready` = 1 after reset is released.
- All outputs are registered; no combinational path from inputs to `set_*`, `cfg_out`, `done` or `cmd_err`.
- Latency: a data byte accepted at edge N gives `cfg_out` = that byte and the strobe high during cycle N→N+1. The block captures the byte at edge N+1.
- `cfg_out` holds its value until the next data byte is accepted, so it is stable across the whole strobe cycle.
- Throughput: addressed write is 3 cycles (addr, data, strobe); stream is 2 cycles per byte.
- At most one `set_*` vector is non-zero in any cycle. `done` and `cmd_err` never assert together.
- Reset asserted mid-operation: strobes drop immediately, the pending command or stream position is lost, and no `done` is produced.

## Test plan

- Reset: hold `rst_n` = 0 with `cfg_valid` toggling -> all strobes 0, `cfg_out` = 0, `cfg_ready` = 1 after release.
- Addressed write: send 0x85 then 0x3C -> exactly one cycle with `cfg_out` = 0x3C and `set_ab` = 1<<5; `cfg_ready` = 0 that cycle; no other strobes.
- Broadcast and error: send 0x3F, 0xAA -> `set_x` all-ones for one cycle. Then send 0x50 (index 16, NUM_BLOCKS = 16), 0x11 -> no strobe, `cmd_err` pulses once.
- Stream load: `stream_mode` = 1, send 64 bytes 0x00..0x3F with random `cfg_valid` gaps -> byte k strobes block k>>2, register k[1:0]; `done` pulses with byte 0x3F only. Byte 65 strobes `set_x[0]`.
- Stream abort and mode change: drop `stream_mode` after 10 bytes -> no `done`, returns to addressed mode. Re-enable -> next byte strobes `set_x[0]`. Raising `stream_mode` between address and data bytes -> the addressed write still completes first.
- Async reset mid-stream: assert `rst_n` = 0 during an S_STROBE cycle -> strobe drops the same cycle; after release the loader is in addressed mode with w = 0.
